i2c_burst_reader: RTL and testbench

Parametrised I2C register-read engine sitting between sensor-control FSMs (e.g. the VL53L0X driver) and the I2C master core. It writes a 1- or 2-byte register address, issues a repeated-start read of N bytes, and buffers them in an internal FIFO. It has its own timeout counter, reports distinct error codes, and applies backpressure instead of failing on overflow.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/i2c_burst_reader.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_burst_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-read engine.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_CMD,
    ST_ADDR_DATA,
    ST_READ_CMD,
    ST_READ_DATA,
    ST_FINISH,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BAD_LEN = 2'd3;

  localparam int CYCLES_PER_MS_27MHZ = 27000;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; a push is
// accepted while full as long as a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign do_pop_s  = pop && (count_r != {CW{1'b0}});
  assign do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);

  assign pop_data  = mem_r[rd_ptr_r];
  assign pop_valid = (count_r != {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/i2c_burst_reader.sv
// I2C register-read engine: writes a 1/2-byte register address, then reads a
// burst with a repeated start into a FWFT FIFO, with timeout and error codes.
module i2c_burst_reader
  import i2c_pkg::*;
#(
  parameter int REG_ADDR_BYTES = 1,
  parameter int MAX_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = CYCLES_PER_MS_27MHZ,
  localparam int CW = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [6:0]    dev_address,
  input  logic [15:0]   reg_address,
  input  logic [CW-1:0] byte_count,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    error_code,
  output logic [6:0]    cmd_address,
  output logic          cmd_start,
  output logic          cmd_read,
  output logic          cmd_write,
  output logic          cmd_stop,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [7:0]    data_out,
  output logic          data_out_valid,
  input  logic          data_out_ready,
  output logic          data_out_last,
  input  logic [7:0]    data_in,
  input  logic          data_in_valid,
  output logic          data_in_ready,
  input  logic          data_in_last,
  input  logic          missed_ack,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [CW-1:0] fifo_count
);

  localparam int   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic LAST_IDX = (REG_ADDR_BYTES == 2) ? 1'b1 : 1'b0;

  state_t        state_r;
  logic [6:0]    dev_r;
  logic [15:0]   reg_r;
  logic [CW-1:0] remaining_r;
  logic          addr_idx_r;
  logic [TW-1:0] tmo_r;
  logic          full_s;
  logic          data_in_ready_s;
  logic          push_s;
  logic          pending_s;
  logic          tmo_hit_s;
  logic          abort_s;
  logic [1:0]    abort_code_s;
  logic          unused_s;

  // Register address bytes go out MSB first.
  function automatic logic [7:0] addr_byte(input logic [15:0] ra, input logic idx);
    if ((REG_ADDR_BYTES == 2) && (idx == 1'b0)) begin
      return ra[15:8];
    end else begin
      return ra[7:0];
    end
  endfunction

  assign unused_s        = data_in_last;
  assign cmd_address     = dev_r;
  assign data_in_ready_s = (state_r == ST_READ_DATA) && !full_s;
  assign data_in_ready   = data_in_ready_s;
  assign push_s          = data_in_ready_s && data_in_valid;
  assign tmo_hit_s       = pending_s && (tmo_r == TW'(TIMEOUT_CYCLES - 1));
  assign abort_s         = (state_r != ST_IDLE) && (missed_ack || tmo_hit_s);
  assign abort_code_s    = missed_ack ? ERR_NACK : ERR_TIMEOUT;

  // A handshake is pending when our side is offering and the master is not.
  always_comb begin
    pending_s = 1'b0;
    case (state_r)
      ST_ADDR_CMD:  pending_s = !cmd_ready;
      ST_ADDR_DATA: pending_s = !data_out_ready;
      ST_READ_CMD:  pending_s = !cmd_ready;
      ST_READ_DATA: pending_s = !push_s;
      default:      pending_s = 1'b0;
    endcase
  end

  // Per-wait timeout; any completed handshake or state change reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_r <= {TW{1'b0}};
    end else if (pending_s && !tmo_hit_s) begin
      tmo_r <= tmo_r + TW'(1);
    end else begin
      tmo_r <= {TW{1'b0}};
    end
  end

  // Main sequencer: command/data handshakes, status pulses and error capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      dev_r          <= 7'd0;
      reg_r          <= 16'd0;
      remaining_r    <= {CW{1'b0}};
      addr_idx_r     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      error_code     <= ERR_NONE;
      cmd_start      <= 1'b0;
      cmd_read       <= 1'b0;
      cmd_write      <= 1'b0;
      cmd_stop       <= 1'b0;
      cmd_valid      <= 1'b0;
      data_out       <= 8'd0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (abort_s) begin
        state_r        <= ST_ERROR;
        error_code     <= abort_code_s;
        cmd_start      <= 1'b0;
        cmd_read       <= 1'b0;
        cmd_write      <= 1'b0;
        cmd_stop       <= 1'b0;
        cmd_valid      <= 1'b0;
        data_out_valid <= 1'b0;
        data_out_last  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              dev_r       <= dev_address;
              reg_r       <= reg_address;
              remaining_r <= byte_count;
              addr_idx_r  <= 1'b0;
              if ((byte_count == {CW{1'b0}}) || (byte_count > CW'(MAX_BYTES))) begin
                error_code <= ERR_BAD_LEN;
                state_r    <= ST_ERROR;
              end else begin
                error_code <= ERR_NONE;
                busy       <= 1'b1;
                cmd_valid  <= 1'b1;
                cmd_start  <= 1'b1;
                cmd_write  <= 1'b1;
                state_r    <= ST_ADDR_CMD;
              end
            end
          end
          ST_ADDR_CMD: begin
            if (cmd_ready) begin
              cmd_valid      <= 1'b0;
              cmd_start      <= 1'b0;
              cmd_write      <= 1'b0;
              data_out       <= addr_byte(reg_r, 1'b0);
              data_out_last  <= (LAST_IDX == 1'b0);
              data_out_valid <= 1'b1;
              state_r        <= ST_ADDR_DATA;
            end
          end
          ST_ADDR_DATA: begin
            if (data_out_ready) begin
              if (addr_idx_r == LAST_IDX) begin
                data_out_valid <= 1'b0;
                data_out_last  <= 1'b0;
                cmd_valid      <= 1'b1;
                cmd_read       <= 1'b1;
                cmd_start      <= 1'b1;
                cmd_stop       <= (remaining_r == CW'(1));
                state_r        <= ST_READ_CMD;
              end else begin
                addr_idx_r    <= addr_idx_r + 1'b1;
                data_out      <= addr_byte(reg_r, 1'b1);
                data_out_last <= 1'b1;
              end
            end
          end
          ST_READ_CMD: begin
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              cmd_read  <= 1'b0;
              cmd_start <= 1'b0;
              cmd_stop  <= 1'b0;
              state_r   <= ST_READ_DATA;
            end
          end
          ST_READ_DATA: begin
            if (push_s) begin
              remaining_r <= remaining_r - CW'(1);
              if (remaining_r == CW'(1)) begin
                state_r <= ST_FINISH;
              end else begin
                cmd_valid <= 1'b1;
                cmd_read  <= 1'b1;
                cmd_stop  <= (remaining_r == CW'(2));
                state_r   <= ST_READ_CMD;
              end
            end
          end
          ST_FINISH: begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
          ST_ERROR: begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(MAX_BYTES)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (data_in),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .pop_valid (rd_valid),
    .full      (full_s),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_i2c_burst_reader.sv
// Directed bench for i2c_burst_reader: one 1-byte-address and one 2-byte-address
// instance share a scripted zero-wait master; each test checks hand-derived values.
module tb_i2c_burst_reader;
  localparam int TMO = 30;
  localparam int CW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_a, start_b;
  logic [6:0] dev_address;
  logic [15:0] reg_address;
  logic [CW-1:0] byte_count;
  logic cmd_ready, data_out_ready, data_in_valid, data_in_last, missed_ack, rd_ready;
  logic [7:0] data_in;

  logic busy_a, done_a, error_a, cs_a, cr_a, cw_a, cp_a, cv_a, dov_a, dol_a, dir_a, rv_a;
  logic busy_b, done_b, error_b, cs_b, cr_b, cw_b, cp_b, cv_b, dov_b, dol_b, dir_b, rv_b;
  logic [1:0] ec_a, ec_b;
  logic [6:0] ca_a, ca_b;
  logic [7:0] do_a, do_b, rd_a, rd_b;
  logic [CW-1:0] fc_a, fc_b;

  i2c_burst_reader #(.REG_ADDR_BYTES(1), .MAX_BYTES(4), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .dev_address(dev_address),
    .reg_address(reg_address), .byte_count(byte_count), .busy(busy_a), .done(done_a),
    .error(error_a), .error_code(ec_a), .cmd_address(ca_a), .cmd_start(cs_a),
    .cmd_read(cr_a), .cmd_write(cw_a), .cmd_stop(cp_a), .cmd_valid(cv_a),
    .cmd_ready(cmd_ready), .data_out(do_a), .data_out_valid(dov_a),
    .data_out_ready(data_out_ready), .data_out_last(dol_a), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_ready(dir_a), .data_in_last(data_in_last),
    .missed_ack(missed_ack), .rd_data(rd_a), .rd_valid(rv_a), .rd_ready(rd_ready),
    .fifo_count(fc_a));

  i2c_burst_reader #(.REG_ADDR_BYTES(2), .MAX_BYTES(4), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .dev_address(dev_address),
    .reg_address(reg_address), .byte_count(byte_count), .busy(busy_b), .done(done_b),
    .error(error_b), .error_code(ec_b), .cmd_address(ca_b), .cmd_start(cs_b),
    .cmd_read(cr_b), .cmd_write(cw_b), .cmd_stop(cp_b), .cmd_valid(cv_b),
    .cmd_ready(cmd_ready), .data_out(do_b), .data_out_valid(dov_b),
    .data_out_ready(data_out_ready), .data_out_last(dol_b), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_ready(dir_b), .data_in_last(data_in_last),
    .missed_ack(missed_ack), .rd_data(rd_b), .rd_valid(rv_b), .rd_ready(rd_ready),
    .fifo_count(fc_b));

  // Observed view of whichever instance the current test drives.
  logic use_b;
  logic o_busy, o_done, o_error, o_cs, o_cr, o_cw, o_cp, o_cv, o_dov, o_dol, o_dir, o_rv;
  logic [1:0] o_ec;
  logic [6:0] o_ca;
  logic [7:0] o_do, o_rd;
  logic [CW-1:0] o_fc;
  assign o_busy = use_b ? busy_b : busy_a;   assign o_done = use_b ? done_b : done_a;
  assign o_error = use_b ? error_b : error_a; assign o_ec = use_b ? ec_b : ec_a;
  assign o_cs = use_b ? cs_b : cs_a;         assign o_cr = use_b ? cr_b : cr_a;
  assign o_cw = use_b ? cw_b : cw_a;         assign o_cp = use_b ? cp_b : cp_a;
  assign o_cv = use_b ? cv_b : cv_a;         assign o_ca = use_b ? ca_b : ca_a;
  assign o_do = use_b ? do_b : do_a;         assign o_dov = use_b ? dov_b : dov_a;
  assign o_dol = use_b ? dol_b : dol_a;      assign o_dir = use_b ? dir_b : dir_a;
  assign o_rd = use_b ? rd_b : rd_a;         assign o_rv = use_b ? rv_b : rv_a;
  assign o_fc = use_b ? fc_b : fc_a;

  int checks = 0;
  int errors = 0;
  logic [7:0] resp [8];
  logic [7:0] addr_log[$];
  logic last_log[$];
  logic [3:0] cmd_log[$];   // {start, read, write, stop}
  logic [6:0] caddr_log[$];
  logic [7:0] rd_log[$];
  int done_cnt, err_cnt, done_cyc, err_cyc, ec2_cyc, first_cv, last_cv, cv_after_nack;
  int pp_before, pp_after, nxt;
  logic end_busy, busy_ever, finished;

  // Scripted master: runs one transaction, logging every handshake it sees.
  task automatic run_txn(input logic b, input logic [6:0] dev, input logic [15:0] ra,
                         input logic [CW-1:0] n, input logic cr, input logic dor,
                         input int rd_gate, input int nack_cyc, input int restart_cyc,
                         input int budget);
    logic push, pop, pp_pend;
    use_b = b;
    addr_log.delete(); last_log.delete(); cmd_log.delete(); caddr_log.delete(); rd_log.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = 0; err_cyc = 0; ec2_cyc = 0; first_cv = 0; last_cv = 0;
    cv_after_nack = 0; pp_before = -1; pp_after = -1; pp_pend = 1'b0; nxt = 0;
    end_busy = 1'b1; busy_ever = 1'b0; finished = 1'b0;
    @(negedge clk);
    dev_address = dev; reg_address = ra; byte_count = n;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      if (cyc == restart_cyc) begin if (b) start_b = 1'b1; else start_a = 1'b1; end
      cmd_ready = cr; data_out_ready = dor; data_in_valid = 1'b1; data_in = resp[nxt];
      missed_ack = (cyc == nack_cyc); rd_ready = (cyc >= rd_gate);
      if (pp_pend) begin pp_after = int'(o_fc); pp_pend = 1'b0; end
      if (o_busy) busy_ever = 1'b1;
      if (o_ec == 2'd2 && ec2_cyc == 0) ec2_cyc = cyc;
      if (o_cv) begin
        if (first_cv == 0) first_cv = cyc;
        last_cv = cyc;
        if (nack_cyc != 0 && cyc > nack_cyc) cv_after_nack++;
      end
      if (o_cv && cmd_ready) begin cmd_log.push_back({o_cs, o_cr, o_cw, o_cp}); caddr_log.push_back(o_ca); end
      if (o_dov && data_out_ready) begin addr_log.push_back(o_do); last_log.push_back(o_dol); end
      push = data_in_valid && o_dir;
      pop = rd_ready && o_rv;
      if (push) nxt++;
      if (pop) rd_log.push_back(o_rd);
      if (push && pop && pp_before < 0) begin pp_before = int'(o_fc); pp_pend = 1'b1; end
      if (o_done) begin done_cnt++; done_cyc = cyc; end_busy = o_busy; end
      if (o_error) begin err_cnt++; err_cyc = cyc; end_busy = o_busy; end
      if (done_cnt + err_cnt > 0) finished = 1'b1;
      if (finished && !pop) break;
    end
    cmd_ready = 1'b0; data_out_ready = 1'b0; data_in_valid = 1'b0; missed_ack = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({busy_a, done_a, error_a} !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", {busy_a, done_a, error_a}); end
    checks++; if (ec_a !== 2'd0) begin errors++; $display("FAIL reset_error_code got %0d want 0", ec_a); end
    checks++; if ({cs_a, cr_a, cw_a, cp_a, cv_a, ca_a} !== 12'd0) begin errors++; $display("FAIL reset_cmd got %h want 0", {cs_a, cr_a, cw_a, cp_a, cv_a, ca_a}); end
    checks++; if ({dov_a, dol_a, dir_a, rv_a} !== 4'd0) begin errors++; $display("FAIL reset_streams got %b want 0000", {dov_a, dol_a, dir_a, rv_a}); end
    checks++; if ({fc_a, fc_b} !== 6'd0) begin errors++; $display("FAIL reset_fifo_count got %h want 0", {fc_a, fc_b}); end
    checks++; if ({busy_b, cv_b, dov_b, rv_b} !== 4'd0) begin errors++; $display("FAIL reset_b got %b want 0000", {busy_b, cv_b, dov_b, rv_b}); end
  endtask

  task automatic test_one_byte_addr;
    resp[0] = 8'hEE; resp[1] = 8'hAA; resp[2] = 8'h10;
    run_txn(1'b0, 7'h29, 16'h00C0, 3'd3, 1'b1, 1'b1, 0, 0, 3, 100);
    checks++; if (!finished) begin errors++; $display("FAIL t1_finish got timeout want done"); end
    checks++; if (addr_log.size() !== 1 || addr_log[0] !== 8'hC0 || last_log[0] !== 1'b1) begin errors++; $display("FAIL t1_addr got n=%0d %h want 1 C0 last", addr_log.size(), addr_log[0]); end
    checks++; if (cmd_log.size() !== 4) begin errors++; $display("FAIL t1_cmd_count got %0d want 4", cmd_log.size()); end
    checks++; if ({cmd_log[0], cmd_log[1], cmd_log[2], cmd_log[3]} !== 16'hAC45) begin errors++; $display("FAIL t1_cmd_flags got %h want AC45", {cmd_log[0], cmd_log[1], cmd_log[2], cmd_log[3]}); end
    checks++; if (caddr_log[0] !== 7'h29 || caddr_log[3] !== 7'h29) begin errors++; $display("FAIL t1_cmd_address got %h want 29", caddr_log[0]); end
    checks++; if (rd_log.size() !== 3 || {rd_log[0], rd_log[1], rd_log[2]} !== 24'hEEAA10) begin errors++; $display("FAIL t1_fifo got n=%0d %h want EEAA10", rd_log.size(), {rd_log[0], rd_log[1], rd_log[2]}); end
    checks++; if (done_cnt !== 1 || err_cnt !== 0) begin errors++; $display("FAIL t1_done_count got %0d/%0d want 1/0", done_cnt, err_cnt); end
    checks++; if (done_cyc !== 10) begin errors++; $display("FAIL t1_latency got %0d want 10", done_cyc); end
    checks++; if (end_busy !== 1'b0 || o_ec !== 2'd0) begin errors++; $display("FAIL t1_end_state got busy=%b ec=%0d want 0 0", end_busy, o_ec); end
  endtask

  task automatic test_two_byte_addr;
    resp[0] = 8'h5A;
    run_txn(1'b1, 7'h52, 16'h1234, 3'd1, 1'b1, 1'b1, 0, 0, 0, 100);
    checks++; if (addr_log.size() !== 2 || {addr_log[0], addr_log[1]} !== 16'h1234) begin errors++; $display("FAIL t2_addr got n=%0d %h%h want 1234", addr_log.size(), addr_log[0], addr_log[1]); end
    checks++; if ({last_log[0], last_log[1]} !== 2'b01) begin errors++; $display("FAIL t2_last got %b%b want 01", last_log[0], last_log[1]); end
    checks++; if (cmd_log.size() !== 2 || {cmd_log[0], cmd_log[1]} !== 8'hAD) begin errors++; $display("FAIL t2_cmds got n=%0d %h%h want AD", cmd_log.size(), cmd_log[0], cmd_log[1]); end
    checks++; if (done_cnt !== 1 || done_cyc !== 7) begin errors++; $display("FAIL t2_done got cnt=%0d cyc=%0d want 1 7", done_cnt, done_cyc); end
    checks++; if (rd_log.size() !== 1 || rd_log[0] !== 8'h5A) begin errors++; $display("FAIL t2_fifo got n=%0d %h want 5A", rd_log.size(), rd_log[0]); end
  endtask

  task automatic test_bad_len;
    for (int k = 0; k < 2; k++) begin
      run_txn(1'b0, 7'h29, 16'h0001, (k == 0) ? 3'd0 : 3'd5, 1'b1, 1'b1, 0, 0, 0, 20);
      checks++; if (err_cnt !== 1 || err_cyc !== 2) begin errors++; $display("FAIL bad_len%0d_error got cnt=%0d cyc=%0d want 1 2", k, err_cnt, err_cyc); end
      checks++; if (o_ec !== 2'd3) begin errors++; $display("FAIL bad_len%0d_code got %0d want 3", k, o_ec); end
      checks++; if (first_cv !== 0 || busy_ever !== 1'b0) begin errors++; $display("FAIL bad_len%0d_quiet got cv=%0d busy=%b want 0 0", k, first_cv, busy_ever); end
    end
  endtask

  task automatic test_nack;
    run_txn(1'b0, 7'h29, 16'h00C0, 3'd2, 1'b1, 1'b0, 0, 3, 0, 40);
    checks++; if (err_cnt !== 1 || err_cyc !== 5) begin errors++; $display("FAIL nack_error got cnt=%0d cyc=%0d want 1 5", err_cnt, err_cyc); end
    checks++; if (o_ec !== 2'd1) begin errors++; $display("FAIL nack_code got %0d want 1", o_ec); end
    checks++; if (end_busy !== 1'b0) begin errors++; $display("FAIL nack_busy got %b want 0", end_busy); end
    checks++; if (cv_after_nack !== 0 || cmd_log.size() !== 1) begin errors++; $display("FAIL nack_no_cmd got %0d/%0d want 0/1", cv_after_nack, cmd_log.size()); end
  endtask

  task automatic test_timeout;
    run_txn(1'b0, 7'h29, 16'h00C0, 3'd2, 1'b0, 1'b1, 0, 0, 0, TMO + 20);
    checks++; if (first_cv !== 1 || last_cv !== TMO) begin errors++; $display("FAIL tmo_cmd_window got %0d..%0d want 1..%0d", first_cv, last_cv, TMO); end
    checks++; if (ec2_cyc !== TMO + 1) begin errors++; $display("FAIL tmo_code_cycle got %0d want %0d", ec2_cyc, TMO + 1); end
    checks++; if (err_cnt !== 1 || err_cyc !== TMO + 2 || end_busy !== 1'b0) begin errors++; $display("FAIL tmo_error got cnt=%0d cyc=%0d busy=%b", err_cnt, err_cyc, end_busy); end
    checks++; if (o_ec !== 2'd2) begin errors++; $display("FAIL tmo_code got %0d want 2", o_ec); end
  endtask

  task automatic test_backpressure;
    resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33; resp[3] = 8'h44;
    run_txn(1'b0, 7'h29, 16'h0010, 3'd4, 1'b1, 1'b1, 1000, 0, 0, 100);
    checks++; if (done_cnt !== 1 || done_cyc !== 12) begin errors++; $display("FAIL bp_fill_done got cnt=%0d cyc=%0d want 1 12", done_cnt, done_cyc); end
    checks++; if (fc_a !== 3'd4 || rv_a !== 1'b1 || rd_a !== 8'h11) begin errors++; $display("FAIL bp_full got cnt=%0d v=%b d=%h want 4 1 11", fc_a, rv_a, rd_a); end
    resp[0] = 8'h55; resp[1] = 8'h66;
    run_txn(1'b0, 7'h29, 16'h0020, 3'd2, 1'b1, 1'b1, 8, 0, 0, 100);
    checks++; if (done_cnt !== 1 || err_cnt !== 0 || done_cyc !== 13) begin errors++; $display("FAIL bp_stall_done got cnt=%0d err=%0d cyc=%0d want 1 0 13", done_cnt, err_cnt, done_cyc); end
    checks++; if (pp_before !== 3 || pp_after !== 3) begin errors++; $display("FAIL bp_push_pop_count got %0d->%0d want 3->3", pp_before, pp_after); end
    checks++; if (rd_log.size() !== 6) begin errors++; $display("FAIL bp_drain_size got %0d want 6", rd_log.size()); end
    checks++; if ({rd_log[0], rd_log[1], rd_log[2], rd_log[3], rd_log[4], rd_log[5]} !== 48'h112233445566) begin errors++; $display("FAIL bp_data got %h want 112233445566", {rd_log[0], rd_log[1], rd_log[2], rd_log[3], rd_log[4], rd_log[5]}); end
    checks++; if (fc_a !== 3'd0 || rv_a !== 1'b0) begin errors++; $display("FAIL bp_empty got cnt=%0d v=%b want 0 0", fc_a, rv_a); end
  endtask

  task automatic test_reset_mid;
    use_b = 1'b0;
    @(negedge clk);
    byte_count = 3'd2; start_a = 1'b1; cmd_ready = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy_a !== 1'b1 || cv_a !== 1'b1) begin errors++; $display("FAIL mid_pre got busy=%b cv=%b want 1 1", busy_a, cv_a); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({busy_a, cv_a, cs_a, cw_a, error_a} !== 5'd0) begin errors++; $display("FAIL mid_reset got %b want 00000", {busy_a, cv_a, cs_a, cw_a, error_a}); end
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; use_b = 1'b0;
    dev_address = 7'h00; reg_address = 16'h0000; byte_count = 3'd0;
    cmd_ready = 1'b0; data_out_ready = 1'b0; data_in_valid = 1'b0; data_in_last = 1'b0;
    missed_ack = 1'b0; rd_ready = 1'b0; data_in = 8'h00;
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    test_reset();
    test_one_byte_addr();
    test_two_byte_addr();
    test_bad_len();
    test_nack();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
